// File: rtl/riscv_mem_responder.sv
`default_nettype none
// ============================================================================
// riscv_mem_responder : latency-programmable byte/half/word memory responder
// Revision 1.0
// ============================================================================
module riscv_mem_responder #(
   parameter int ADDR_WIDTH = 12,
   parameter int LATENCY    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_RE,
   input  logic        mem_WE,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [2:0]  funct3,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        busy,
   output logic        err
);
   localparam int         IDX_W    = ADDR_WIDTH - 2;
   localparam int         DEPTH    = 1 << IDX_W;
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic                   req_we_q, req_we_d;
   logic                   req_bad_q, req_bad_d;
   logic [ADDR_WIDTH-1:0]  req_addr_q, req_addr_d;
   logic [31:0]            req_wdata_q, req_wdata_d;
   logic [2:0]             req_funct3_q, req_funct3_d;
   logic [31:0]            rdata_q, rdata_d;
   logic                   resp_err_q, resp_err_d;

   logic [31:0]            mem [DEPTH];

   logic                   sample;
   logic                   access;
   logic                   acc_we;
   logic                   acc_bad;
   logic [ADDR_WIDTH-1:0]  acc_addr;
   logic [31:0]            acc_wdata;
   logic [2:0]             acc_f3;
   logic                   f3_ok;
   logic                   align_ok;
   logic                   acc_err;
   logic                   mem_wr;
   logic [3:0]             wr_be;
   logic [31:0]            wr_data;
   logic [31:0]            rd_word;
   logic [7:0]             ld_byte;
   logic [15:0]            ld_half;
   logic [31:0]            ld_data;

   generate
      if (ADDR_WIDTH < 32) begin : g_addr_alias
         logic unused_addr_hi;
         assign unused_addr_hi = ^addr[31:ADDR_WIDTH];
      end
   endgenerate

   always_comb begin
      sample       = (state_q == S_IDLE) && (mem_RE || mem_WE);
      state_d      = state_q;
      cnt_d        = cnt_q;
      access       = 1'b0;
      req_we_d     = req_we_q;
      req_bad_d    = req_bad_q;
      req_addr_d   = req_addr_q;
      req_wdata_d  = req_wdata_q;
      req_funct3_d = req_funct3_q;
      case (state_q)
         S_IDLE: begin
            if (sample) begin
               req_we_d     = mem_WE;
               req_bad_d    = mem_RE && mem_WE;
               req_addr_d   = addr[ADDR_WIDTH-1:0];
               req_wdata_d  = wdata;
               req_funct3_d = funct3;
               cnt_d        = CNT_INIT;
               if (LATENCY == 1) begin
                  state_d = S_RESP;
                  access  = 1'b1;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = S_RESP;
               access  = 1'b1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // With LATENCY = 1 the access happens on the sampling edge itself, so
   // the live inputs stand in for the not-yet-latched request.
   always_comb begin
      if (state_q == S_IDLE) begin
         acc_we    = mem_WE;
         acc_bad   = mem_RE && mem_WE;
         acc_addr  = addr[ADDR_WIDTH-1:0];
         acc_wdata = wdata;
         acc_f3    = funct3;
      end else begin
         acc_we    = req_we_q;
         acc_bad   = req_bad_q;
         acc_addr  = req_addr_q;
         acc_wdata = req_wdata_q;
         acc_f3    = req_funct3_q;
      end
   end

   always_comb begin
      f3_ok    = 1'b0;
      align_ok = 1'b1;
      case (acc_f3)
         3'b000, 3'b100: f3_ok = !(acc_f3[2] && acc_we);
         3'b001, 3'b101: begin
            f3_ok    = !(acc_f3[2] && acc_we);
            align_ok = !acc_addr[0];
         end
         3'b010: begin
            f3_ok    = 1'b1;
            align_ok = (acc_addr[1:0] == 2'b00);
         end
         default: f3_ok = 1'b0;
      endcase
      acc_err = acc_bad || !f3_ok || !align_ok;
   end

   always_comb begin
      rd_word = mem[acc_addr[ADDR_WIDTH-1:2]];
      ld_byte = rd_word[{acc_addr[1:0], 3'b000} +: 8];
      ld_half = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];
      case (acc_f3[1:0])
         2'b00:   ld_data = {{24{!acc_f3[2] && ld_byte[7]}}, ld_byte};
         2'b01:   ld_data = {{16{!acc_f3[2] && ld_half[15]}}, ld_half};
         default: ld_data = rd_word;
      endcase
   end

   // Store data is replicated across lanes so the byte enables alone select it.
   always_comb begin
      case (acc_f3[1:0])
         2'b00: begin
            wr_be   = 4'b0001 << acc_addr[1:0];
            wr_data = {4{acc_wdata[7:0]}};
         end
         2'b01: begin
            wr_be   = acc_addr[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{acc_wdata[15:0]}};
         end
         default: begin
            wr_be   = 4'b1111;
            wr_data = acc_wdata;
         end
      endcase
      mem_wr = access && acc_we && !acc_err && rst_n;
   end

   always_comb begin
      rdata_d    = rdata_q;
      resp_err_d = resp_err_q;
      if (access) begin
         resp_err_d = acc_err;
         if (acc_err) begin
            rdata_d = 32'h0;
         end else if (!acc_we) begin
            rdata_d = ld_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= 4'd0;
         req_we_q     <= 1'b0;
         req_bad_q    <= 1'b0;
         req_addr_q   <= '0;
         req_wdata_q  <= 32'h0;
         req_funct3_q <= 3'b000;
         rdata_q      <= 32'h0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         req_we_q     <= req_we_d;
         req_bad_q    <= req_bad_d;
         req_addr_q   <= req_addr_d;
         req_wdata_q  <= req_wdata_d;
         req_funct3_q <= req_funct3_d;
         rdata_q      <= rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_wr) begin
         for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) begin
               mem[acc_addr[ADDR_WIDTH-1:2]][8*i +: 8] <= wr_data[8*i +: 8];
            end
         end
      end
   end

   assign ready = (state_q == S_RESP);
   assign err   = ready && resp_err_q;
   assign busy  = (state_q != S_IDLE);
   assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_mem_responder.sv
`default_nettype none
// ============================================================================
// tb_riscv_mem_responder : model-checked bench for two latency configurations
// Revision 1.0
// ============================================================================
module tb_riscv_mem_responder;
   localparam int LAT0 = 2;
   localparam int LAT1 = 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        re = 1'b0, we = 1'b0, re1 = 1'b0, we1 = 1'b0;
   logic [31:0] addr = 32'h0, wdata = 32'h0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] rdata, rdata1;
   logic        ready, busy, err, ready1, busy1, err1;

   int n_checks = 0;
   int n_errors = 0;
   int ready_pulses = 0;

   riscv_mem_responder #(.ADDR_WIDTH(12), .LATENCY(LAT0)) dut (
      .clk(clk), .rst_n(rst_n), .mem_RE(re), .mem_WE(we), .addr(addr),
      .wdata(wdata), .funct3(funct3), .rdata(rdata), .ready(ready),
      .busy(busy), .err(err));

   riscv_mem_responder #(.ADDR_WIDTH(12), .LATENCY(LAT1)) dut1 (
      .clk(clk), .rst_n(rst_n), .mem_RE(re1), .mem_WE(we1), .addr(addr),
      .wdata(wdata), .funct3(funct3), .rdata(rdata1), .ready(ready1),
      .busy(busy1), .err(err1));

   always #5 clk = ~clk;

   // Reference model: one outstanding request per instance, counted in edges.
   int          lat_of [2] = '{LAT0, LAT1};
   bit          m_pend [2] = '{0, 0};
   int          m_left [2] = '{0, 0};
   bit          m_ready [2] = '{0, 0};
   bit          m_err [2] = '{0, 0};
   bit          m_busy [2] = '{0, 0};
   logic [31:0] m_rdata [2] = '{32'h0, 32'h0};
   bit          q_we [2], q_both [2];
   logic [31:0] q_addr [2], q_wd [2];
   logic [2:0]  q_f3 [2];
   logic [31:0] mmem [int];

   task automatic model_access(input int k);
      logic [31:0] w, val;
      logic [2:0]  f;
      int          lane, key, sz;
      bit          bad;
      f    = q_f3[k];
      lane = int'(q_addr[k] % 4);
      key  = k * 4096 + int'((q_addr[k] % 4096) / 4);
      w    = mmem.exists(key) ? mmem[key] : 32'h0;
      bad  = q_both[k];
      if (q_we[k]) bad = bad || (f > 3'd2);
      else         bad = bad || !(f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      sz = 1 << f[1:0];
      if ((q_addr[k] % sz) != 0) bad = 1'b1;
      m_ready[k] = 1'b1;
      m_err[k]   = bad;
      if (bad) begin
         m_rdata[k] = 32'h0;
      end else if (q_we[k]) begin
         for (int b = 0; b < sz; b++) w[8*(lane+b) +: 8] = q_wd[k][8*b +: 8];
         mmem[key] = w;
      end else begin
         val = w >> (8 * lane);
         if (sz == 1)      val = f[2] ? {24'h0, val[7:0]}  : {{24{val[7]}}, val[7:0]};
         else if (sz == 2) val = f[2] ? {16'h0, val[15:0]} : {{16{val[15]}}, val[15:0]};
         m_rdata[k] = val;
      end
   endtask

   task automatic model_step(input int k, input bit r, input bit w);
      if (m_ready[k]) begin
         m_ready[k] = 1'b0;
         m_err[k]   = 1'b0;
      end else if (m_pend[k]) begin
         m_left[k]--;
         if (m_left[k] == 0) begin
            m_pend[k] = 1'b0;
            model_access(k);
         end
      end else if (r || w) begin
         q_we[k]   = w;
         q_both[k] = r && w;
         q_addr[k] = addr;
         q_wd[k]   = wdata;
         q_f3[k]   = funct3;
         if (lat_of[k] == 1) begin
            model_access(k);
         end else begin
            m_pend[k] = 1'b1;
            m_left[k] = lat_of[k] - 1;
         end
      end
      m_busy[k] = m_pend[k] || m_ready[k];
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            m_pend[k] = 0; m_left[k] = 0; m_ready[k] = 0;
            m_err[k] = 0; m_busy[k] = 0; m_rdata[k] = 32'h0;
         end
      end else begin
         model_step(0, re, we);
         model_step(1, re1, we1);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (ready) ready_pulses++;
         chk("cyc0_ready", {31'h0, ready}, {31'h0, m_ready[0]});
         chk("cyc0_err",   {31'h0, err},   {31'h0, m_err[0]});
         chk("cyc0_busy",  {31'h0, busy},  {31'h0, m_busy[0]});
         chk("cyc0_rdata", rdata, m_rdata[0]);
         chk("cyc1_ready", {31'h0, ready1}, {31'h0, m_ready[1]});
         chk("cyc1_err",   {31'h0, err1},   {31'h0, m_err[1]});
         chk("cyc1_busy",  {31'h0, busy1},  {31'h0, m_busy[1]});
         chk("cyc1_rdata", rdata1, m_rdata[1]);
      end
   end

   task automatic set_strobe(input int k, input bit r, input bit w);
      if (k == 0) begin re = r; we = w; end
      else        begin re1 = r; we1 = w; end
   endtask

   // Entered and left at posedge+2 with the instance idle.
   task automatic do_req(input string nm, input int k, input bit r, input bit w,
                         input logic [31:0] a, input logic [2:0] f, input logic [31:0] d,
                         input bit eerr, input bit chkd, input logic [31:0] exp);
      int n;
      bit seen;
      addr = a; funct3 = f; wdata = d;
      set_strobe(k, r, w);
      @(posedge clk); #2;
      set_strobe(k, 1'b0, 1'b0);
      seen = 1'b0;
      n = 0;
      while (!seen && n < 20) begin
         @(negedge clk);
         n++;
         seen = (k == 0) ? ready : ready1;
      end
      if (!seen) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s_timeout: no ready after %0d cycles, expected within 20", nm, n);
      end else begin
         chk({nm, "_latency"}, n, (k == 0) ? LAT0 : LAT1);
         chk({nm, "_err"}, {31'h0, (k == 0) ? err : err1}, {31'h0, eerr});
         chk({nm, "_model_err"}, {31'h0, m_err[k]}, {31'h0, eerr});
         if (chkd) begin
            chk({nm, "_rdata"}, (k == 0) ? rdata : rdata1, exp);
            chk({nm, "_model_rdata"}, m_rdata[k], exp);
         end
      end
      @(posedge clk); #2;
   endtask

   task automatic chk_reset_outputs(input string nm);
      chk({nm, "_ready"}, {31'h0, ready}, 32'h0);
      chk({nm, "_busy"},  {31'h0, busy},  32'h0);
      chk({nm, "_err"},   {31'h0, err},   32'h0);
      chk({nm, "_rdata"}, rdata, 32'h0);
   endtask

   initial begin
      int p0;
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      repeat (3) @(posedge clk);
      #2;
      chk_reset_outputs("rst0");
      chk("rst1_rdata", rdata1, 32'h0);
      chk("rst1_busy", {31'h0, busy1}, 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #2;

      do_req("sw10",  0, 0, 1, 32'h10, 3'b010, 32'hDEADBEEF, 0, 0, 32'h0);
      do_req("lw10",  0, 1, 0, 32'h10, 3'b010, 32'h0, 0, 1, 32'hDEADBEEF);
      do_req("lb13",  0, 1, 0, 32'h13, 3'b000, 32'h0, 0, 1, 32'hFFFFFFDE);
      do_req("lbu13", 0, 1, 0, 32'h13, 3'b100, 32'h0, 0, 1, 32'h000000DE);
      do_req("lh12",  0, 1, 0, 32'h12, 3'b001, 32'h0, 0, 1, 32'hFFFFDEAD);
      do_req("lhu10", 0, 1, 0, 32'h10, 3'b101, 32'h0, 0, 1, 32'h0000BEEF);
      do_req("sb11",  0, 0, 1, 32'h11, 3'b000, 32'hFFFFFF55, 0, 0, 32'h0);
      do_req("lw_sb", 0, 1, 0, 32'h10, 3'b010, 32'h0, 0, 1, 32'hDEAD55EF);
      do_req("sh12",  0, 0, 1, 32'h12, 3'b001, 32'hFFFF1234, 0, 0, 32'h0);
      do_req("lw_sh", 0, 1, 0, 32'h10, 3'b010, 32'h0, 0, 1, 32'h123455EF);

      do_req("rej_lw12", 0, 1, 0, 32'h12, 3'b010, 32'h0, 1, 1, 32'h0);
      do_req("lw_r1",    0, 1, 0, 32'h10, 3'b010, 32'h0, 0, 1, 32'h123455EF);
      do_req("rej_sh11", 0, 0, 1, 32'h11, 3'b001, 32'h0000AAAA, 1, 1, 32'h0);
      do_req("lw_r2",    0, 1, 0, 32'h10, 3'b010, 32'h0, 0, 1, 32'h123455EF);
      do_req("rej_f3_3", 0, 1, 0, 32'h10, 3'b011, 32'h0, 1, 1, 32'h0);
      do_req("lw_r3",    0, 1, 0, 32'h10, 3'b010, 32'h0, 0, 1, 32'h123455EF);
      do_req("rej_both", 0, 1, 1, 32'h10, 3'b010, 32'h0, 1, 1, 32'h0);
      do_req("lw_r4",    0, 1, 0, 32'h10, 3'b010, 32'h0, 0, 1, 32'h123455EF);
      do_req("rej_sbu",  0, 0, 1, 32'h10, 3'b100, 32'h0, 1, 1, 32'h0);

      // Strobe held through the WAIT and RESP edges must not start a second access.
      p0 = ready_pulses;
      addr = 32'h10; funct3 = 3'b010; re = 1'b1;
      @(posedge clk); #2;
      @(posedge clk); #2;
      @(posedge clk); #2;
      re = 1'b0;
      repeat (6) @(posedge clk);
      #2;
      chk("ignore_pulses", ready_pulses - p0, 32'd1);
      chk("ignore_busy", {31'h0, busy}, 32'h0);
      chk("ignore_rdata", rdata, 32'h123455EF);

      do_req("l1_sw40",  1, 0, 1, 32'h40, 3'b010, 32'h0BADF00D, 0, 0, 32'h0);
      do_req("l1_lw40",  1, 1, 0, 32'h40, 3'b010, 32'h0, 0, 1, 32'h0BADF00D);
      do_req("l1_lb41",  1, 1, 0, 32'h41, 3'b000, 32'h0, 0, 1, 32'hFFFFFFF0);
      do_req("l1_alias", 1, 1, 0, 32'h1042, 3'b101, 32'h0, 0, 1, 32'h00000BAD);
      do_req("l1_rej",   1, 1, 0, 32'h42, 3'b010, 32'h0, 1, 1, 32'h0);

      // Reset mid-WAIT: the second store is aborted.
      do_req("sw20",  0, 0, 1, 32'h20, 3'b010, 32'hA5A5A5A5, 0, 0, 32'h0);
      addr = 32'h20; funct3 = 3'b010; wdata = 32'h0; we = 1'b1;
      @(posedge clk); #2;
      we = 1'b0;
      chk("midwait_busy", {31'h0, busy}, 32'h1);
      #1 rst_n = 1'b0;
      #1;
      chk_reset_outputs("midwait_rst");
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #2;
      do_req("lw20", 0, 1, 0, 32'h20, 3'b010, 32'h0, 0, 1, 32'hA5A5A5A5);

      // Reset during RESP drops ready at once; the store already landed.
      addr = 32'h24; funct3 = 3'b010; wdata = 32'h600DCAFE; we = 1'b1;
      @(posedge clk); #2;
      we = 1'b0;
      @(posedge clk); #2;
      chk("resp_ready", {31'h0, ready}, 32'h1);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("resp_rst");
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #2;
      do_req("lw24", 0, 1, 0, 32'h24, 3'b010, 32'h0, 0, 1, 32'h600DCAFE);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
